// File: rtl/ebr_pkg.sv
// Shared constants, payload types and lane helpers for the EBR port arbiter.
package ebr_pkg;

  localparam int unsigned EBR_X16 = 0;
  localparam int unsigned EBR_X8  = 1;
  localparam int unsigned EBR_X4  = 2;
  localparam int unsigned EBR_X2  = 3;

  localparam int unsigned EBR_WORD_W      = 16;
  localparam int unsigned EBR_ADDR_W      = 8;
  localparam int unsigned EBR_ELEM_ADDR_W = 11;
  localparam int unsigned EBR_LANE_W      = 3;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } ebr_port_e;

  // One registered access to the physical port.
  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [EBR_ADDR_W-1:0] addr;
    logic [EBR_WORD_W-1:0] wdata;
    logic [EBR_WORD_W-1:0] mask;
  } ebr_cmd_t;

  // In-flight bookkeeping that routes read data back to its requester.
  typedef struct packed {
    logic                  rd;
    ebr_port_e             port;
    logic [EBR_LANE_W-1:0] lane;
  } ebr_tag_t;

  localparam ebr_cmd_t EBR_CMD_IDLE = '{
    en:    1'b0,
    we:    1'b0,
    addr:  8'h00,
    wdata: 16'h0000,
    mask:  16'hFFFF
  };

  // RAM bit i belongs to lane (i mod 2^mode); bits of the selected lane are writable.
  function automatic logic [EBR_WORD_W-1:0] lane_mask(input int unsigned mode,
                                                      input logic [EBR_LANE_W-1:0] lane);
    logic [EBR_WORD_W-1:0] m;
    int unsigned           lm;
    lm = (32'd1 << mode) - 32'd1;
    m  = '1;
    for (int unsigned i = 0; i < EBR_WORD_W; i++) begin
      if ((i & lm) == 32'(lane)) begin
        m[4'(i)] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ebr_lane_map.sv
// Element <-> 16-bit word mapping for one requester of fixed width MODE.
module ebr_lane_map
  import ebr_pkg::*;
#(
  parameter int unsigned MODE = EBR_X16
) (
  input  logic [EBR_ELEM_ADDR_W-1:0] addr,
  input  logic [EBR_WORD_W-1:0]      wdata,
  input  logic [EBR_LANE_W-1:0]      rd_lane,
  input  logic [EBR_WORD_W-1:0]      ram_rdata,
  output logic [EBR_ADDR_W-1:0]      word_c,
  output logic [EBR_LANE_W-1:0]      lane_c,
  output logic [EBR_WORD_W-1:0]      mask_c,
  output logic [EBR_WORD_W-1:0]      wdata_c,
  output logic [EBR_WORD_W-1:0]      rdata_c
);

  localparam int unsigned     STRIDE     = 32'd1 << MODE;
  localparam int unsigned     ELEM_W     = EBR_WORD_W >> MODE;
  localparam int unsigned     LANE_MSK_I = STRIDE - 32'd1;
  localparam logic [EBR_LANE_W-1:0] LANE_MSK = EBR_LANE_W'(LANE_MSK_I);

  generate
    if (MODE > EBR_X2) begin : g_bad_mode
      $error("ebr_lane_map: MODE must be in 0..3");
    end
  endgenerate

  // Address bits above the mode's range and wdata bits above the element are don't-care.
  logic unused_in;
  assign unused_in = ^{addr, wdata};

  assign word_c = addr[EBR_ADDR_W-1+MODE:MODE];
  assign lane_c = addr[EBR_LANE_W-1:0] & LANE_MSK;
  assign mask_c = lane_mask(MODE, lane_c);

  // Element bit j lands on RAM bit j*2^MODE + lane.
  always_comb begin
    wdata_c = '0;
    for (int unsigned i = 0; i < EBR_WORD_W; i++) begin
      if ((i & LANE_MSK_I) == 32'(lane_c)) begin
        wdata_c[4'(i)] = wdata[4'(i >> MODE)];
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    for (int unsigned j = 0; j < ELEM_W; j++) begin
      rdata_c[4'(j)] = ram_rdata[4'(j * STRIDE + 32'(rd_lane & LANE_MSK))];
    end
  end

endmodule

// File: rtl/ebr_port_arbiter.sv
// Round-robin sharing of one 256x16 EBR port between two fixed-width requesters.
module ebr_port_arbiter
  import ebr_pkg::*;
#(
  parameter int unsigned MODE_A = EBR_X16,
  parameter int unsigned MODE_B = EBR_X16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic                       a_we,
  input  logic [EBR_ELEM_ADDR_W-1:0] a_addr,
  input  logic [EBR_WORD_W-1:0]      a_wdata,
  output logic                       a_rsp_valid,
  output logic [EBR_WORD_W-1:0]      a_rdata,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic                       b_we,
  input  logic [EBR_ELEM_ADDR_W-1:0] b_addr,
  input  logic [EBR_WORD_W-1:0]      b_wdata,
  output logic                       b_rsp_valid,
  output logic [EBR_WORD_W-1:0]      b_rdata,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [EBR_ADDR_W-1:0]      ram_addr,
  output logic [EBR_WORD_W-1:0]      ram_wdata,
  output logic [EBR_WORD_W-1:0]      ram_mask,
  input  logic [EBR_WORD_W-1:0]      ram_rdata
);

  logic     last_gnt_b;
  logic     grant_a_c;
  logic     grant_b_c;
  ebr_cmd_t cmd_q;
  ebr_cmd_t cmd_nxt_c;
  ebr_tag_t tag_nxt_c;
  ebr_tag_t tag1_q;
  ebr_tag_t tag2_q;

  logic [EBR_ADDR_W-1:0] word_a_c;
  logic [EBR_ADDR_W-1:0] word_b_c;
  logic [EBR_LANE_W-1:0] lane_a_c;
  logic [EBR_LANE_W-1:0] lane_b_c;
  logic [EBR_WORD_W-1:0] mask_a_c;
  logic [EBR_WORD_W-1:0] mask_b_c;
  logic [EBR_WORD_W-1:0] wdata_a_c;
  logic [EBR_WORD_W-1:0] wdata_b_c;
  logic [EBR_WORD_W-1:0] rdata_a_c;
  logic [EBR_WORD_W-1:0] rdata_b_c;

  ebr_lane_map #(.MODE(MODE_A)) u_map_a (
    .addr      (a_addr),
    .wdata     (a_wdata),
    .rd_lane   (tag2_q.lane),
    .ram_rdata (ram_rdata),
    .word_c    (word_a_c),
    .lane_c    (lane_a_c),
    .mask_c    (mask_a_c),
    .wdata_c   (wdata_a_c),
    .rdata_c   (rdata_a_c)
  );

  ebr_lane_map #(.MODE(MODE_B)) u_map_b (
    .addr      (b_addr),
    .wdata     (b_wdata),
    .rd_lane   (tag2_q.lane),
    .ram_rdata (ram_rdata),
    .word_c    (word_b_c),
    .lane_c    (lane_b_c),
    .mask_c    (mask_b_c),
    .wdata_c   (wdata_b_c),
    .rdata_c   (rdata_b_c)
  );

  // The side not served most recently wins a tie; nothing is granted while in reset.
  assign grant_a_c = resetn & a_valid & (~b_valid | last_gnt_b);
  assign grant_b_c = resetn & b_valid & (~a_valid | ~last_gnt_b);
  assign a_ready   = grant_a_c;
  assign b_ready   = grant_b_c;

  always_comb begin
    cmd_nxt_c = EBR_CMD_IDLE;
    tag_nxt_c = '0;
    if (grant_a_c) begin
      cmd_nxt_c.en   = 1'b1;
      cmd_nxt_c.we   = a_we;
      cmd_nxt_c.addr = word_a_c;
      if (a_we) begin
        cmd_nxt_c.wdata = wdata_a_c;
        cmd_nxt_c.mask  = mask_a_c;
      end
      tag_nxt_c.rd   = ~a_we;
      tag_nxt_c.port = PORT_A;
      tag_nxt_c.lane = lane_a_c;
    end else if (grant_b_c) begin
      cmd_nxt_c.en   = 1'b1;
      cmd_nxt_c.we   = b_we;
      cmd_nxt_c.addr = word_b_c;
      if (b_we) begin
        cmd_nxt_c.wdata = wdata_b_c;
        cmd_nxt_c.mask  = mask_b_c;
      end
      tag_nxt_c.rd   = ~b_we;
      tag_nxt_c.port = PORT_B;
      tag_nxt_c.lane = lane_b_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_gnt_b <= 1'b1;
    end else if (grant_a_c) begin
      last_gnt_b <= 1'b0;
    end else if (grant_b_c) begin
      last_gnt_b <= 1'b1;
    end
  end

  // Command register feeds the EBR; tag stages track the command and the read-data cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_q  <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      cmd_q  <= cmd_nxt_c;
      tag1_q <= tag_nxt_c;
      tag2_q <= tag1_q;
    end
  end

  assign ram_en    = cmd_q.en;
  assign ram_we    = cmd_q.we;
  assign ram_addr  = cmd_q.addr;
  assign ram_wdata = cmd_q.wdata;
  assign ram_mask  = cmd_q.mask;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      a_rsp_valid <= tag2_q.rd & (tag2_q.port == PORT_A);
      b_rsp_valid <= tag2_q.rd & (tag2_q.port == PORT_B);
      if (tag2_q.rd && (tag2_q.port == PORT_A)) begin
        a_rdata <= rdata_a_c;
      end
      if (tag2_q.rd && (tag2_q.port == PORT_B)) begin
        b_rdata <= rdata_b_c;
      end
    end
  end

endmodule

// File: tb/tb_ebr_port_arbiter.sv
// Scoreboard bench: two arbiter instances (x2/x4 and x16/x8) share one request stream.
module tb_ebr_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        a_valid, a_we, b_valid, b_we;
  logic [10:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;

  logic        ar [2];
  logic        br [2];
  logic        arv [2];
  logic        brv [2];
  logic [15:0] ard [2];
  logic [15:0] brd [2];
  logic        ren [2];
  logic        rwe [2];
  logic [7:0]  radr [2];
  logic [15:0] rwd [2];
  logic [15:0] rmk [2];
  logic [15:0] rrd [2];

  always #5 clk = ~clk;

  ebr_port_arbiter #(.MODE_A(3), .MODE_B(2)) dut0 (
    .clk(clk), .resetn(resetn),
    .a_valid(a_valid), .a_ready(ar[0]), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(arv[0]), .a_rdata(ard[0]),
    .b_valid(b_valid), .b_ready(br[0]), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(brv[0]), .b_rdata(brd[0]),
    .ram_en(ren[0]), .ram_we(rwe[0]), .ram_addr(radr[0]), .ram_wdata(rwd[0]),
    .ram_mask(rmk[0]), .ram_rdata(rrd[0])
  );

  ebr_port_arbiter #(.MODE_A(0), .MODE_B(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .a_valid(a_valid), .a_ready(ar[1]), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(arv[1]), .a_rdata(ard[1]),
    .b_valid(b_valid), .b_ready(br[1]), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(brv[1]), .b_rdata(brd[1]),
    .ram_en(ren[1]), .ram_we(rwe[1]), .ram_addr(radr[1]), .ram_wdata(rwd[1]),
    .ram_mask(rmk[1]), .ram_rdata(rrd[1])
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic armed;
  logic mem_clear;

  task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model of the raw EBR primitive (256x16, bit mask, registered read).
  logic [15:0] ebr_mem [2][256];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_clear) begin
        for (int w = 0; w < 256; w++) ebr_mem[d][w] <= '0;
      end else if (ren[d]) begin
        if (rwe[d]) ebr_mem[d][radr[d]] <= (ebr_mem[d][radr[d]] & rmk[d]) | (rwd[d] & ~rmk[d]);
        else        rrd[d] <= ebr_mem[d][radr[d]];
      end
    end
  end

  // Reference model: element-level memory per instance plus expected command/response.
  typedef struct packed {
    logic        en;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] mask;
  } cmd_t;

  typedef struct {
    int          due;
    int          d;
    int          p;
    logic [15:0] data;
  } rsp_t;

  logic [15:0] ref_mem [2][256];
  cmd_t        exp_cmd [2];
  rsp_t        rq [$];
  rsp_t        r;
  int          last_served;
  int          winner;
  bit          exp_v [2][2];
  logic [15:0] exp_dat [2][2];
  int          m, s, n, ad, word, lane, bitn;
  logic        we_g;
  logic [15:0] wd_g, mk, dat, e;

  function automatic int mode_of(input int d, input int p);
    if (d == 0) return (p == 0) ? 3 : 2;
    return (p == 0) ? 0 : 1;
  endfunction

  always @(negedge clk) begin
    if (mem_clear) begin
      for (int d = 0; d < 2; d++)
        for (int w = 0; w < 256; w++) ref_mem[d][w] = '0;
    end
    if (!armed) begin
      for (int d = 0; d < 2; d++) exp_cmd[d] = '0;
      last_served = 1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk("ram_en",    d, ren[d],  exp_cmd[d].en);
        chk("ram_we",    d, rwe[d],  exp_cmd[d].we);
        chk("ram_addr",  d, radr[d], exp_cmd[d].addr);
        chk("ram_wdata", d, rwd[d],  exp_cmd[d].wdata);
        chk("ram_mask",  d, rmk[d],  exp_cmd[d].mask);
      end
      for (int d = 0; d < 2; d++) begin
        exp_v[d][0] = 0;
        exp_v[d][1] = 0;
      end
      while (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        exp_v[r.d][r.p]   = 1;
        exp_dat[r.d][r.p] = r.data;
      end
      for (int d = 0; d < 2; d++) begin
        chk("a_rsp_valid", d, arv[d], exp_v[d][0]);
        chk("b_rsp_valid", d, brv[d], exp_v[d][1]);
        if (exp_v[d][0]) chk("a_rdata", d, ard[d], exp_dat[d][0]);
        if (exp_v[d][1]) chk("b_rdata", d, brd[d], exp_dat[d][1]);
      end
      // Who gets served: sole requester, or whoever was not served last.
      winner = -1;
      if (resetn) begin
        if (a_valid && b_valid) winner = (last_served == 1) ? 0 : 1;
        else if (a_valid)       winner = 0;
        else if (b_valid)       winner = 1;
      end
      for (int d = 0; d < 2; d++) begin
        chk("a_ready", d, ar[d], winner == 0);
        chk("b_ready", d, br[d], winner == 1);
      end
      if (!resetn) begin
        rq.delete();
        last_served = 1;
        for (int d = 0; d < 2; d++) exp_cmd[d] = '0;
      end else if (winner < 0) begin
        for (int d = 0; d < 2; d++) exp_cmd[d] = '{en: 1'b0, we: 1'b0, addr: 8'h00, wdata: 16'h0000, mask: 16'hFFFF};
      end else begin
        for (int d = 0; d < 2; d++) begin
          m    = mode_of(d, winner);
          s    = 1 << m;
          n    = 16 / s;
          ad   = (winner == 0) ? int'(a_addr) : int'(b_addr);
          we_g = (winner == 0) ? a_we : b_we;
          wd_g = (winner == 0) ? a_wdata : b_wdata;
          word = (ad / s) % 256;
          lane = ad % s;
          exp_cmd[d].en   = 1'b1;
          exp_cmd[d].we   = we_g;
          exp_cmd[d].addr = 8'(word);
          if (we_g) begin
            mk  = 16'hFFFF;
            dat = 16'h0000;
            for (int j = 0; j < n; j++) begin
              bitn = j * s + lane;
              mk[bitn]  = 1'b0;
              dat[bitn] = wd_g[j];
              ref_mem[d][word][bitn] = wd_g[j];
            end
            exp_cmd[d].wdata = dat;
            exp_cmd[d].mask  = mk;
          end else begin
            e = 16'h0000;
            for (int j = 0; j < n; j++) e[j] = ref_mem[d][word][j * s + lane];
            rq.push_back('{due: cyc + 3, d: d, p: winner, data: e});
            exp_cmd[d].wdata = 16'h0000;
            exp_cmd[d].mask  = 16'hFFFF;
          end
        end
        last_served = winner;
      end
    end
  end

  task automatic issue(input int p, input logic we, input logic [10:0] addr, input logic [15:0] wd);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (p == 0) begin a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    else        begin b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (p == 0) ? ar[0] : br[0];
    end
    chk("grant_wait", p, got, 1'b1);
    @(posedge clk); #1;
    if (p == 0) a_valid = 1'b0; else b_valid = 1'b0;
  endtask

  logic ga, gb;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; mem_clear = 1'b1; armed = 1'b0;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1; mem_clear = 1'b0; armed = 1'b1;
    @(posedge clk); #1; resetn = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_en", 0, ren[0], 1'b0);
    chk("idle_mask", 0, rmk[0], 16'hFFFF);

    // x2 write on A of dut0: addr 0x005 is word 0, lane 5.
    issue(0, 1'b1, 11'h005, 16'h0003);
    @(negedge clk);
    chk("x2_we", 0, rwe[0], 1'b1);
    chk("x2_addr", 0, radr[0], 8'h00);
    chk("x2_mask", 0, rmk[0], 16'hDFDF);
    chk("x2_wdata", 0, rwd[0], 16'h2020);

    // Fresh reset so A wins the first tie, then both valid every cycle.
    @(posedge clk); #1; resetn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; resetn = 1'b1;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 11'($urandom);
    b_valid = 1'b1; b_we = 1'b0; b_addr = 11'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("alt_a", 0, ar[0], (k % 2) == 0);
      chk("alt_b", 0, br[0], (k % 2) == 1);
      ga = ar[0];
      @(posedge clk); #1;
      if (ga) a_addr = 11'($urandom); else b_addr = 11'($urandom);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // x4 write then read-back on B of dut0: addr 0x0A7 is word 0x29, lane 3.
    issue(1, 1'b1, 11'h0A7, 16'h0009);
    @(negedge clk);
    chk("x4_addr", 0, radr[0], 8'h29);
    chk("x4_mask", 0, rmk[0], 16'h7777);
    issue(1, 1'b0, 11'h0A7, 16'h0000);
    repeat (3) @(negedge clk);
    chk("x4_rsp_valid", 0, brv[0], 1'b1);
    chk("x4_rdata", 0, brd[0], 16'h0009);
    chk("x4_a_quiet", 0, arv[0], 1'b0);

    // Mixed widths on dut1: x16 clears word 0x10, x8 fills lane 1, x16 reads back.
    issue(0, 1'b1, 11'h010, 16'h0000);
    issue(1, 1'b1, 11'h021, 16'h00FF);
    issue(0, 1'b0, 11'h010, 16'h0000);
    repeat (3) @(negedge clk);
    chk("mix_rsp_valid", 1, arv[1], 1'b1);
    chk("mix_rdata", 1, ard[1], 16'hAAAA);

    // Reset one cycle after a read grant drops the response.
    issue(0, 1'b0, 11'h005, 16'h0000);
    resetn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 11'h001;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 11'h002;
    @(negedge clk);
    chk("post_reset_a", 0, ar[0], 1'b1);
    @(posedge clk); #1; a_valid = 1'b0;
    @(posedge clk); #1; b_valid = 1'b0;

    // Randomised traffic; requests hold until granted.
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      ga = ar[0];
      gb = br[0];
      @(posedge clk); #1;
      if (!a_valid || ga) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_we    = 1'($urandom_range(0, 1));
        a_addr  = 11'($urandom & 32'h10F);
        a_wdata = 16'($urandom);
      end
      if (!b_valid || gb) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = 11'($urandom & 32'h10F);
        b_wdata = 16'($urandom);
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain", 0, 16'(rq.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ebr_port_arbiter.md
# ebr_port_arbiter

Shares one iCE40UP 256x16 EBR port between two requesters, A and B. Each requester has its own fixed logical width: 256x16, 512x8, 1024x4 or 2048x2. The block round-robins requests onto the single physical port, generates the per-bit write mask and lane-replicated write data for narrow writes, and extracts narrow read data from the 16-bit word. It sits between client logic and a raw EBR primitive that always runs in 256x16 mode with its bit mask enabled.

## Interface
- MODE_A, default 0: requester A width mode. 0=x16, 1=x8, 2=x4, 3=x2. Any other value is an elaboration error.
- MODE_B, default 0: requester B width mode, same encoding.
- clk  in  1  sole clock; every register is rising-edge.
- resetn  in  1  synchronous, active-low reset.
- a_valid / b_valid  in  1  request present.
- a_ready / b_ready  out  1  request accepted this cycle (grant).
- a_we / b_we  in  1  1=write, 0=read.
- a_addr / b_addr  in  11  element address. Bits [7+m:0] are used for mode m; upper bits are ignored.
- a_wdata / b_wdata  in  16  write element in the low 16>>m bits; upper bits are ignored.
- a_rsp_valid / b_rsp_valid  out  1  one-cycle pulse with read data.
- a_rdata / b_rdata  out  16  read element in the low 16>>m bits; upper bits are zero.
- ram_en  out  1  EBR access strobe.
- ram_we  out  1  EBR write enable.
- ram_addr  out  8  EBR word address.
- ram_wdata  out  16  replicated write data.
- ram_mask  out  16  1 = bit NOT written.
- ram_rdata  in  16  EBR read data, valid one cycle after ram_en with ram_we=0.

## Operation
- Address split for mode m:
  - word = addr[7+m:m].
  - lane = addr[m-1:0]; lane = 0 when m=0.
- Lane mapping, bit-interleaved:
  - Element bit j maps to RAM bit j*2^m + lane, for j in 0..(16>>m)-1.
  - Resulting masks:
    - mode 0: mask 0x0000.
    - mode 1: lane0 0xAAAA, lane1 0x5555.
    - mode 2: lanes 0..3 give 0xEEEE, 0xDDDD, 0xBBBB, 0x7777.
    - mode 3: lanes 0..7 give 0xFEFE, 0xFDFD, 0xFBFB, 0xF7F7, 0xEFEF, 0xDFDF, 0xBFBF, 0x7F7F.
- Write data: mapped element bits are placed at their RAM bits. Unmapped ram_wdata bits are 0; they are masked anyway.
- Reads: ram_mask = 0xFFFF and ram_wdata = 0. The element is extracted from ram_rdata using the inverse mapping.
- Arbitration:
  - Single valid requester: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - After reset, A has priority.
  - At most one grant per cycle. x_ready is combinational from the valids and the last-grant register.
  - A requester holds valid and its payload stable until ready.
- Responses:
  - No backpressure; rsp_valid is a pulse the client must take.
  - Writes produce no response.
  - A 2-entry in-flight tag pipeline carries the port id, read flag and lane, so responses return in grant order to the correct port.
- Reset: all outputs 0, last-grant = B (so A wins first). In-flight reads are dropped; no rsp_valid fires for them after reset is released.

## Timing
- Cycle T: grant (x_valid & x_ready).
- T+1: ram_en, ram_we, ram_addr, ram_wdata and ram_mask are valid (registered).
- T+2: ram_rdata is valid from the EBR.
- T+3: x_rsp_valid=1 and x_rdata are valid (registered). Read latency is 3 cycles.
- ram_en=0 in any cycle following a no-grant cycle. In that case ram_we=0 and ram_mask=0xFFFF.
- Throughput: one access per cycle. Back-to-back grants alternate A/B while both are valid.
- Write followed by read to the same word: the read is issued at least one cycle later and returns the written data. The EBR is write-first per cycle and the order is preserved.
- Reset asserted at cycle R: outputs are 0 from R+1. Inputs sampled during reset are ignored.

## Structure
- Package ebr_pkg:
  - Mode constants: EBR_X16=0, EBR_X8=1, EBR_X4=2, EBR_X2=3.
  - EBR_WORD_W=16 and EBR_ADDR_W=8.
  - Function lane_mask(mode, lane) returning 16 bits.
- Sub-module ebr_lane_map, parameter MODE:
  - Combinational.
  - Inputs: addr and wdata. Outputs: word, mask and replicated data.
  - Also extracts rdata given a lane.
  - Instantiated once per requester.
- Top level holds the arbiter, command register, tag pipeline and response registers.

## Test plan
- Reset, then idle → ram_en=0, ram_mask=0xFFFF and all rsp_valid=0 for 10 cycles.
- MODE_A=3, A writes addr 0x005 data 0x3 → at T+1: ram_addr=0x00, ram_mask=0xDFDF, ram_wdata=0x2020, ram_we=1.
- MODE_A=1, MODE_B=2, both valid every cycle → grants alternate A,B,A,B starting with A. No cycle has two readies.
- MODE_B=2, B writes addr 0x0A7 (word 0x29, lane 3) data 0x9, then reads it → ram_mask=0x7777 on the write. b_rsp_valid fires 3 cycles after the read grant with b_rdata=0x0009. a_rsp_valid stays 0.
- Mixed widths on one word: A (x16) writes word 0x10 = 0x0000, then B (x8) writes addr 0x021 with data 0xFF, then A reads word 0x10 → a_rdata=0xAAAA.
- Reset asserted one cycle after a read grant → no rsp_valid after reset release. The next grant goes to A.
